// File: rtl/io_input_cond_pkg.sv
// Shared I/O port layout: bit offsets used by io_input_cond, io_output and CPU decode.
package io_pkg;
    localparam int IO_PORT_W   = 32;
    localparam int KEY_EVT_LSB = 16;
    localparam int KEY_DB_LSB  = 0;
    localparam int SW_DB_LSB   = 0;
endpackage

// File: rtl/io_input_cond_if.sv
// Board-input bundle between the raw pins / clear strobe and the input conditioner.
interface io_input_cond_if #(
    parameter int SW_W  = 10,
    parameter int KEY_W = 4
);
    import io_pkg::*;

    logic [SW_W-1:0]      sw_raw;
    logic [KEY_W-1:0]     key_raw;
    logic                 evt_clr;
    logic [KEY_W-1:0]     evt_clr_mask;
    logic [IO_PORT_W-1:0] in_port0;
    logic [IO_PORT_W-1:0] in_port1;

    modport master (
        output sw_raw, key_raw, evt_clr, evt_clr_mask,
        input  in_port0, in_port1
    );

    modport slave (
        input  sw_raw, key_raw, evt_clr, evt_clr_mask,
        output in_port0, in_port1
    );
endinterface

// File: rtl/io_input_cond_debounce_bit.sv
// Single-bit 2-flop synchroniser plus debounce counter and stable flop.
// IO_INPUT_DB_BYPASS_EN drops the counter: stable is the synchroniser output.
module io_debounce_bit #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);
    if (DB_CYCLES < 2 || (longint'(1) << CNT_W) <= longint'(DB_CYCLES)) begin : g_bad_param
        $error("io_debounce_bit: need DB_CYCLES >= 2 and 2**CNT_W > DB_CYCLES");
    end

    logic s1;
    logic s2;

`ifdef IO_INPUT_DB_BYPASS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign stable = s2;
    assign rise   = s1 & ~s2;
`else
    logic [CNT_W-1:0] cnt;
    logic             hit;

    // hit marks the edge on which stable adopts the synchronised level
    assign hit  = (s2 != stable) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign rise = hit & s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (hit) begin
                cnt    <= '0;
                stable <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/io_input_cond.sv
// Input conditioner: debounced switches/keys and sticky key-press events on two ports.
// Optional IO_INPUT_DB_BYPASS_EN removes the debounce counters.
module io_input_cond
    import io_pkg::*;
#(
    parameter int SW_W      = 10,
    parameter int KEY_W     = 4,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input logic            io_clk,
    input logic            reset,
    io_input_cond_if.slave bus
);
    localparam int N = SW_W + KEY_W;

    logic [N-1:0]     raw;
    logic [N-1:0]     db;
    logic [N-1:0]     rise;
    logic [KEY_W-1:0] key_evt;
    logic [KEY_W-1:0] clr;
    logic             unused_sw_rise;

    // keys are active-low on the board; invert so 1 means pressed
    assign raw = {~bus.key_raw, bus.sw_raw};

    for (genvar i = 0; i < N; i++) begin : g_bit
        io_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk    (io_clk),
            .reset  (reset),
            .raw    (raw[i]),
            .stable (db[i]),
            .rise   (rise[i])
        );
    end

    assign unused_sw_rise = ^rise[SW_W-1:0];
    assign clr = bus.evt_clr ? bus.evt_clr_mask : '0;

    // set has priority over clear so a press coinciding with a clear survives
    always_ff @(posedge io_clk) begin
        if (reset) begin
            key_evt <= '0;
        end else begin
            key_evt <= (key_evt & ~clr) | rise[N-1:SW_W];
        end
    end

    always_comb begin
        bus.in_port0 = '0;
        bus.in_port1 = '0;
        bus.in_port0[SW_DB_LSB +: SW_W]    = db[SW_W-1:0];
        bus.in_port1[KEY_DB_LSB +: KEY_W]  = db[N-1:SW_W];
        bus.in_port1[KEY_EVT_LSB +: KEY_W] = key_evt;
    end
endmodule

// File: tb/tb_io_input_cond.sv
// Self-checking bench for io_input_cond: directed plan plus random stimulus vs a window model.
module tb_io_input_cond;
    localparam int SW_W  = 10;
    localparam int KEY_W = 4;
    localparam int DB    = 8;
    localparam int CNT_W = 4;
    localparam int N     = SW_W + KEY_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    io_input_cond_if #(.SW_W(SW_W), .KEY_W(KEY_W)) bus ();

    io_input_cond #(
        .SW_W      (SW_W),
        .KEY_W     (KEY_W),
        .DB_CYCLES (DB),
        .CNT_W     (CNT_W)
    ) dut (
        .io_clk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int passed = 0;

    // hist[k] = value sampled k edges ago (hist[0] = this edge)
    logic [N-1:0]     hist [0:DB+1];
    logic [N-1:0]     m_db  = '0;
    logic [KEY_W-1:0] m_evt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // A bit adopts a level once DB consecutive synchronised samples agree on it
    task automatic model_edge();
        logic [N-1:0] rawv;
        logic [N-1:0] nxt;
        logic         same;
        rawv = {~bus.key_raw, bus.sw_raw};
        if (reset) begin
            for (int j = 0; j <= DB + 1; j++) hist[j] = '0;
            m_db  = '0;
            m_evt = '0;
        end else begin
            for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = rawv;
            nxt = m_db;
            for (int b = 0; b < N; b++) begin
                same = 1'b1;
                for (int j = 3; j <= DB + 1; j++)
                    if (hist[j][b] != hist[2][b]) same = 1'b0;
                if (same && hist[2][b] != m_db[b]) nxt[b] = hist[2][b];
            end
            m_evt = (m_evt & ~(bus.evt_clr ? bus.evt_clr_mask : '0))
                  | (nxt[N-1:SW_W] & ~m_db[N-1:SW_W]);
            m_db = nxt;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("model_port0", bus.in_port0, 32'(m_db[SW_W-1:0]));
            check("model_port1", bus.in_port1,
                  32'(m_db[N-1:SW_W]) | (32'(m_evt) << 16));
        end
    endtask

    initial begin
        for (int j = 0; j <= DB + 1; j++) hist[j] = '0;
        bus.sw_raw       = 10'h3FF;
        bus.key_raw      = 4'h0;
        bus.evt_clr      = 1'b0;
        bus.evt_clr_mask = '0;

        // reset with all inputs active
        reset = 1'b1;
        ticks(2);
        check("rst_port0", bus.in_port0, 32'h0);
        check("rst_port1", bus.in_port1, 32'h0);
        reset = 1'b0;
        ticks(9);
        check("post_rst_9_port0", bus.in_port0, 32'h0);
        check("post_rst_9_port1", bus.in_port1, 32'h0);
        ticks(1);
        check("post_rst_10_port0", bus.in_port0, 32'h0000_03FF);
        check("post_rst_10_port1", bus.in_port1, 32'h000F_000F);

        bus.sw_raw  = '0;
        bus.key_raw = 4'hF;
        ticks(12);
        check("release_port1", bus.in_port1, 32'h000F_0000);
        bus.evt_clr      = 1'b1;
        bus.evt_clr_mask = 4'hF;
        ticks(1);
        bus.evt_clr = 1'b0;
        check("clear_all", bus.in_port1, 32'h0);

        // clean switch change
        bus.sw_raw = 10'h2A5;
        ticks(9);
        check("sw_edge9", bus.in_port0, 32'h0);
        ticks(1);
        check("sw_edge10", bus.in_port0, 32'h0000_02A5);

        // bounce rejection on bit 0
        bus.sw_raw = '0;
        ticks(12);
        for (int i = 0; i < 20; i++) begin
            bus.sw_raw[0] = ~bus.sw_raw[0];
            ticks(1);
            check("bounce_hold", 32'(bus.in_port0[0]), 32'h0);
        end
        bus.sw_raw[0] = 1'b1;
        ticks(9);
        check("settle_9", bus.in_port0, 32'h0);
        ticks(1);
        check("settle_10", bus.in_port0, 32'h1);

        // key press and release
        bus.key_raw = 4'hB;
        ticks(9);
        check("key_press_9", bus.in_port1, 32'h0);
        ticks(1);
        check("key_press_10", bus.in_port1, 32'h0004_0004);
        bus.key_raw = 4'hF;
        ticks(10);
        check("key_release", bus.in_port1, 32'h0004_0000);

        // clear coinciding with press edge, then clear one cycle later
        bus.evt_clr      = 1'b1;
        bus.evt_clr_mask = 4'h4;
        ticks(1);
        bus.evt_clr = 1'b0;
        check("evt_cleared", bus.in_port1, 32'h0);
        bus.key_raw = 4'hB;
        ticks(9);
        bus.evt_clr = 1'b1;
        ticks(1);
        check("set_wins", bus.in_port1, 32'h0004_0004);
        ticks(1);
        bus.evt_clr = 1'b0;
        check("late_clear", 32'(bus.in_port1[18]), 32'h0);

        // reset in the middle of a debounce count
        bus.sw_raw = 10'h009;
        ticks(4);
        reset = 1'b1;
        ticks(1);
        check("mid_rst_port0", bus.in_port0, 32'h0);
        check("mid_rst_port1", bus.in_port1, 32'h0);
        reset = 1'b0;
        ticks(9);
        check("mid_rst_9", 32'(bus.in_port0[3]), 32'h0);
        ticks(1);
        check("mid_rst_10", bus.in_port0, 32'h0000_0009);

        // random levels, glitches, clears and occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) bus.sw_raw ^= SW_W'($urandom);
            if ($urandom_range(4) == 0) bus.key_raw ^= KEY_W'(1 << $urandom_range(KEY_W - 1));
            bus.evt_clr      = ($urandom_range(7) == 0);
            bus.evt_clr_mask = KEY_W'($urandom);
            reset            = ($urandom_range(199) == 0);
            ticks(1);
        end
        reset       = 1'b0;
        bus.evt_clr = 1'b0;
        ticks(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
